dfp_cmd_queue_tx: RTL and testbench
===================================

# dfp_cmd_queue_tx

Parametrised DFPlayer command transmitter and successor to the fixed single-frame sender. It accepts arbitrary commands (code, 16-bit parameter, feedback flag) through a valid/ready handshake into a small FIFO. It builds each frame, including a computed checksum, and serialises it at a configurable baud rate. It enforces a configurable idle gap between frames and sits between the control logic and the DFPlayer RX pin.

## Interface
- CLK_HZ, 50_000_000, system clock frequency in Hz
- BAUD, 9600, UART bit rate; DIV = CLK_HZ/BAUD cycles per bit (integer division), DIV ≥ 2
- DEPTH, 4, command FIFO entries; power of two, ≥ 2
- GAP_CLKS, 1_000_000, idle cycles (tx high) after each frame, ≥ 1
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- cmd_valid  input  1  command offered
- cmd_ready  output  1  FIFO not full; reset 1
- cmd_code  input  8  DFPlayer command byte
- cmd_param  input  16  parameter, high byte sent first
- cmd_fb  input  1  1 = request module feedback (FB byte 0x01, else 0x00)
- tx  output  1  UART line, idle high; reset 1
- busy  output  1  frame in flight or gap running; reset 0
- frame_done  output  1  one-cycle pulse at end of last stop bit; reset 0
- fifo_level  output  $clog2(DEPTH)+1  entries queued; reset 0

## Operation
- Push: when cmd_valid && cmd_ready, {cmd_fb, cmd_code, cmd_param} is written on the clock edge. cmd_ready depends only on full, so a push while full is refused even if a pop occurs in the same cycle.
- Simultaneous push and pop when not full: level unchanged.
- Frame bytes, in order: 7E FF 06 CMD FB PH PL CSH CSL EF.
- Checksum = 16'h0000 − (FF+06+CMD+FB+PH+PL), in 16-bit wrap-around arithmetic. It is computed from the latched entry, not from live inputs.
- FSM states:
  - IDLE: tx=1, busy=0. If the FIFO is not empty, pop it, latch the entry, go to LOAD.
  - LOAD: compute the checksum, set byte index to 0, go to SEND.
  - SEND: serialise the byte at the current index. After its stop bit, advance the index. After the last byte, pulse frame_done and go to GAP.
  - GAP: hold tx=1 for GAP_CLKS cycles, then go to IDLE.
- busy is 1 in LOAD, SEND and GAP.
- Byte serialiser: start bit 0, D0..D7 LSB first, stop bit 1. Each bit lasts exactly DIV cycles, so one byte takes 10·DIV cycles.
- Bytes within a frame are back-to-back, with no idle cycles between a stop bit and the next start bit.
- Reset at any point, including mid-frame:
  - tx returns to 1 immediately.
  - The FIFO is emptied and the FSM goes to IDLE.
  - Any partial frame is abandoned and not resumed.
- Parameter changes to cmd_* while not accepted have no effect.

## Timing
- With IDLE and an empty FIFO, a command accepted at edge t gives:
  - pop at t+1
  - LOAD at t+2
  - tx falls (start bit) at t+3
- Frame length is N·10·DIV cycles, with N = 10 (8 if the checksum is compiled out).
- frame_done is asserted during the final cycle of the last stop bit.
- Next start bit: no earlier than GAP_CLKS + 2 cycles after frame_done.
- fifo_level updates the cycle after the push/pop edge. cmd_ready is registered from it.

## Configuration
- DFP_CHECKSUM_EN defined: 10-byte frame including CSH, CSL; LOAD computes the checksum.
- Not defined: 8-byte frame 7E FF 06 CMD FB PH PL EF. The checksum logic is absent and the byte index wraps at 8.

## Structure
- Package dfp_pkg holds:
  - byte constants: START 8'h7E, VER 8'hFF, LEN 8'h06, END 8'hEF
  - FSM state enum
  - command codes: PLAY_TRACK 8'h03, SET_VOLUME 8'h06
- One sub-module, dfp_uart_byte_tx. It takes parameter DIV and has ports load, data[7:0], tx, done. It does bit timing only.
- The FIFO and FSM stay in the top module.

## Test plan
- Compile with DFP_CHECKSUM_EN and use small timing parameters: CLK_HZ=1000, BAUD=100 (DIV=10), GAP_CLKS=20. Push cmd 03, param 0001, fb 0. The decoded bytes must be 7E FF 06 03 00 00 01 FE F7 EF, and frame_done must fire exactly 1000 cycles after the start-bit falling edge.
- Push cmd 06, param 001E, fb 1. The checksum bytes must be FE D6, the FB byte must be 01, and every bit width must be 10 cycles.
- Hold cmd_valid for DEPTH+2 pushes while the first frame is sending:
  - cmd_ready must drop when fifo_level reaches DEPTH.
  - Refused commands must never be sent.
  - Frames must follow in order, each separated by ≥ 20 idle-high cycles.
- Assert reset_n low in the middle of byte 4. tx must read 1 in the same cycle, busy and fifo_level must read 0, and after release no bytes may appear until a new push.
- Compile without DFP_CHECKSUM_EN and push cmd 03, param 0001. The output must be exactly the 8 bytes 7E FF 06 03 00 00 01 EF, with frame_done 800 cycles after the start bit.

Source files
------------

// File: rtl/dfp_pkg.sv
// DFPlayer command transmitter shared definitions: frame byte constants,
// FSM state encoding, queued command layout and frame length.
// Build option: DFP_CHECKSUM_EN adds the two checksum bytes to every frame.
package dfp_pkg;

  localparam logic [7:0] START = 8'h7E;
  localparam logic [7:0] VER   = 8'hFF;
  localparam logic [7:0] LEN   = 8'h06;
  localparam logic [7:0] END   = 8'hEF;

  localparam logic [7:0] PLAY_TRACK = 8'h03;
  localparam logic [7:0] SET_VOLUME = 8'h06;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_GAP  = 2'd3
  } dfp_state_t;

  typedef struct packed {
    logic        fb;
    logic [7:0]  code;
    logic [15:0] param;
  } dfp_cmd_t;

`ifdef DFP_CHECKSUM_EN
  localparam int NBYTES = 10;

  // Two's-complement of the 16-bit sum of VER..PL, wrapping.
  function automatic logic [15:0] dfp_checksum(input dfp_cmd_t c);
    logic [15:0] sum;
    sum = 16'(VER) + 16'(LEN) + 16'(c.code) + {15'd0, c.fb}
        + 16'(c.param[15:8]) + 16'(c.param[7:0]);
    return 16'h0000 - sum;
  endfunction
`else
  localparam int NBYTES = 8;
`endif

endpackage

// File: rtl/dfp_uart_byte_tx.sv
// Purpose: 8N1 serialiser for one byte; start bit, D0..D7 LSB first, stop bit.
// Latency: tx drops the cycle after load; done is high in the last stop-bit cycle.
// Backpressure: none; a new load is accepted during the done cycle for gapless bytes.
module dfp_uart_byte_tx #(
  parameter int DIV = 5208
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(DIV - 2);

  logic          active;
  logic [3:0]    bit_cnt;   // 0 = start, 1..8 = data, 9 = stop
  logic [CW-1:0] clk_cnt;
  logic [7:0]    shreg;

  // Bit timing: each bit holds for DIV cycles; done is raised one cycle early so it lines up with the last stop cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active  <= 1'b0;
      bit_cnt <= '0;
      clk_cnt <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        active  <= 1'b1;
        bit_cnt <= '0;
        clk_cnt <= '0;
        shreg   <= data;
        tx      <= 1'b0;
      end else if (active) begin
        if (clk_cnt == CNT_LAST) begin
          clk_cnt <= '0;
          if (bit_cnt == 4'd9) begin
            active <= 1'b0;
            tx     <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 4'd1;
            tx      <= (bit_cnt == 4'd8) ? 1'b1 : shreg[bit_cnt[2:0]];
          end
        end else begin
          clk_cnt <= clk_cnt + 1'b1;
          if (bit_cnt == 4'd9 && clk_cnt == CNT_PRE) done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/dfp_cmd_queue_tx.sv
// Purpose: queue DFPlayer commands and send each as a UART frame followed by an idle gap.
// Latency: command accepted at edge t -> pop t+1, LOAD t+2, start bit t+3.
// Backpressure: cmd_ready is low while the FIFO is full (registered from the level).
// Build option: DFP_CHECKSUM_EN selects the 10-byte frame with CSH/CSL.
module dfp_cmd_queue_tx
  import dfp_pkg::*;
#(
  parameter int CLK_HZ   = 50_000_000,
  parameter int BAUD     = 9600,
  parameter int DEPTH    = 4,
  parameter int GAP_CLKS = 1_000_000
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [7:0]               cmd_code,
  input  logic [15:0]              cmd_param,
  input  logic                     cmd_fb,
  output logic                     tx,
  output logic                     busy,
  output logic                     frame_done,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int DIV   = CLK_HZ / BAUD;
  localparam int AW    = $clog2(DEPTH);
  localparam int IDX_W = $clog2(NBYTES);
  localparam int GW    = $clog2(GAP_CLKS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);
  localparam logic [GW-1:0]    GAP_LAST = GW'(GAP_CLKS - 1);
  localparam logic [AW:0]      FULL_LVL = (AW + 1)'(DEPTH);

  dfp_cmd_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     level_nxt;
  logic            push, pop;

  dfp_state_t      state;
  dfp_cmd_t        cur;
  logic [IDX_W-1:0] idx, sel_idx;
  logic            start_pend;
  logic [GW-1:0]   gap_cnt;
  logic [7:0]      byte_dat;
  logic            byte_load, byte_done;
`ifdef DFP_CHECKSUM_EN
  logic [15:0]     csum;
`endif

  assign push = cmd_valid && cmd_ready;
  assign pop  = (state == ST_IDLE) && (fifo_level != '0);

  // Next occupancy; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    level_nxt = fifo_level;
    if (push && !pop)      level_nxt = fifo_level + 1'b1;
    else if (!push && pop) level_nxt = fifo_level - 1'b1;
  end

  // Command storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{fb: cmd_fb, code: cmd_code, param: cmd_param};
  end

  // FIFO pointers, level and the registered ready flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      cmd_ready  <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_level <= level_nxt;
      cmd_ready  <= (level_nxt != FULL_LVL);
    end
  end

  // The first byte is loaded on the cycle after LOAD; later bytes load in the
  // done cycle of the previous one so stop and next start bits abut.
  assign byte_load  = (state == ST_SEND) && (start_pend || (byte_done && idx != LAST_IDX));
  assign sel_idx    = start_pend ? idx : idx + 1'b1;
  assign frame_done = (state == ST_SEND) && !start_pend && byte_done && (idx == LAST_IDX);

  // Frame byte selection from the latched command.
  always_comb begin
    byte_dat = END;
    case (sel_idx)
      IDX_W'(0): byte_dat = START;
      IDX_W'(1): byte_dat = VER;
      IDX_W'(2): byte_dat = LEN;
      IDX_W'(3): byte_dat = cur.code;
      IDX_W'(4): byte_dat = {7'd0, cur.fb};
      IDX_W'(5): byte_dat = cur.param[15:8];
      IDX_W'(6): byte_dat = cur.param[7:0];
`ifdef DFP_CHECKSUM_EN
      IDX_W'(7): byte_dat = csum[15:8];
      IDX_W'(8): byte_dat = csum[7:0];
`endif
      default:   byte_dat = END;
    endcase
  end

  // Frame sequencer: pop, build, send bytes, then enforce the idle gap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      cur        <= '0;
      idx        <= '0;
      start_pend <= 1'b0;
      gap_cnt    <= '0;
`ifdef DFP_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (pop) begin
            cur   <= mem[rd_ptr];
            busy  <= 1'b1;
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
`ifdef DFP_CHECKSUM_EN
          csum       <= dfp_checksum(cur);
`endif
          idx        <= '0;
          start_pend <= 1'b1;
          state      <= ST_SEND;
        end
        ST_SEND: begin
          if (start_pend) begin
            start_pend <= 1'b0;
          end else if (byte_done) begin
            if (idx == LAST_IDX) begin
              gap_cnt <= '0;
              state   <= ST_GAP;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  dfp_uart_byte_tx #(.DIV(DIV)) u_byte_tx (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (byte_load),
    .data    (byte_dat),
    .tx      (tx),
    .done    (byte_done)
  );

endmodule

// File: tb/tb_dfp_cmd_queue_tx.sv
// Bench for dfp_cmd_queue_tx with DIV=10 and a 20-cycle gap; expected frame
// bytes are queued at push time and matched against bytes decoded from tx.
// Frame length follows DFP_CHECKSUM_EN (10 bytes defined, 8 otherwise).
module tb_dfp_cmd_queue_tx;

  localparam int CLK_HZ = 1000;
  localparam int BAUD   = 100;
  localparam int DIV    = 10;
  localparam int DEPTH  = 4;
  localparam int GAP    = 20;
  localparam int LW     = $clog2(DEPTH) + 1;
`ifdef DFP_CHECKSUM_EN
  localparam int NB = 10;
`else
  localparam int NB = 8;
`endif
  localparam int FRAME_CYC = NB * 10 * DIV;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic [7:0]    cmd_code = 8'h00;
  logic [15:0]   cmd_param = 16'h0000;
  logic          cmd_fb = 1'b0;
  logic          cmd_ready, tx, busy, frame_done;
  logic [LW-1:0] fifo_level;

  int checks = 0;
  int failures = 0;

  dfp_cmd_queue_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DEPTH(DEPTH), .GAP_CLKS(GAP)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_code(cmd_code), .cmd_param(cmd_param), .cmd_fb(cmd_fb), .tx(tx),
    .busy(busy), .frame_done(frame_done), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard and UART line monitor (samples on the falling edge).
  logic [7:0]  exp_q[$];
  logic [7:0]  rx_q[$];
  int unsigned rx_t[$];
  int unsigned fd_t[$];
  int          width_err = 0;
  int          frame_err = 0;
  bit          mon_act = 1'b0;
  int          mon_k = 0;
  logic [7:0]  mon_sh = 8'h00;
  logic        mon_prev = 1'b1;
  int unsigned mon_s = 0;

  always @(negedge clk) begin
    if (reset_n !== 1'b1) begin
      mon_act = 1'b0;
    end else begin
      if (frame_done === 1'b1) fd_t.push_back(cyc);
      if (!mon_act) begin
        if (tx === 1'b0) begin
          mon_act = 1'b1;
          mon_k   = 0;
          mon_s   = cyc;
        end
      end else begin
        mon_k++;
        if (tx !== mon_prev && (mon_k % DIV) != 0) width_err++;
        if ((mon_k % DIV) == DIV / 2) begin
          if (mon_k / DIV >= 1 && mon_k / DIV <= 8) mon_sh[mon_k / DIV - 1] = tx;
          else if (mon_k / DIV == 9 && tx !== 1'b1) frame_err++;
        end
        if (mon_k == DIV / 2 && tx !== 1'b0) frame_err++;
        if (mon_k == 10 * DIV - 1) begin
          rx_q.push_back(mon_sh);
          rx_t.push_back(mon_s);
          mon_act = 1'b0;
        end
      end
    end
    mon_prev = tx;
  end

  function automatic void exp_frame(input logic [7:0] c, input logic [15:0] p, input logic f);
    logic [15:0] cs;
    cs = 16'h0000 - (16'h00FF + 16'h0006 + {8'h00, c} + {15'd0, f} + {8'h00, p[15:8]} + {8'h00, p[7:0]});
    exp_q.push_back(8'h7E); exp_q.push_back(8'hFF); exp_q.push_back(8'h06);
    exp_q.push_back(c);     exp_q.push_back({7'd0, f});
    exp_q.push_back(p[15:8]); exp_q.push_back(p[7:0]);
`ifdef DFP_CHECKSUM_EN
    exp_q.push_back(cs[15:8]); exp_q.push_back(cs[7:0]);
`endif
    exp_q.push_back(8'hEF);
  endfunction

  task automatic clear_sb();
    exp_q.delete(); rx_q.delete(); rx_t.delete(); fd_t.delete();
    width_err = 0; frame_err = 0;
  endtask

  // Offer one command for one cycle; acc is cmd_ready at the sampling edge.
  task automatic offer(input logic [7:0] c, input logic [15:0] p, input logic f,
                       output bit acc, output int unsigned at);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_code = c; cmd_param = p; cmd_fb = f;
    acc = cmd_ready;
    at  = cyc;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_code  = 8'($urandom);
    cmd_param = 16'($urandom);
    cmd_fb    = 1'($urandom);
  endtask

  task automatic wait_rx(input int n, input int budget, output bit ok);
    int b;
    b = budget;
    while (rx_q.size() < n && b > 0) begin
      @(negedge clk);
      b--;
    end
    ok = (rx_q.size() >= n);
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    int b;
    b = budget;
    @(negedge clk);
    while (busy !== 1'b0 && b > 0) begin
      @(negedge clk);
      b--;
    end
    ok = (busy === 1'b0);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx got=%b want=1", tx); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done got=%b want=0", frame_done); end
    checks++; if (fifo_level !== '0) begin failures++; $display("FAIL reset_level got=%0d want=0", fifo_level); end
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", cmd_ready); end
    @(posedge clk); #2;
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  // Literal single frames: byte values, start latency, frame_done timing, bit widths.
  task automatic test_single(input string nm, input logic [7:0] c, input logic [15:0] p, input logic f,
                             input logic [7:0] lit [10]);
    bit ok, acc; int unsigned at; logic [7:0] got, e;
    clear_sb();
    for (int i = 0; i < NB; i++) exp_q.push_back(lit[i]);
    offer(c, p, f, acc, at);
    checks++; if (acc !== 1'b1) begin failures++; $display("FAIL %s_accept got=%b want=1", nm, acc); end
    wait_rx(NB, FRAME_CYC + 200, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL %s_timeout got=%0d bytes want=%0d", nm, rx_q.size(), NB);
    end else begin
      checks++; if (rx_t[0] != at + 4) begin failures++; $display("FAIL %s_start_latency got=%0d want=%0d", nm, rx_t[0] - at, 4); end
      for (int i = 0; i < NB; i++) begin
        got = rx_q.pop_front(); e = exp_q.pop_front();
        checks++; if (got !== e) begin failures++; $display("FAIL %s_byte%0d got=%h want=%h", nm, i, got, e); end
      end
      checks++; if (rx_t[NB-1] - rx_t[0] != (NB - 1) * 10 * DIV) begin failures++; $display("FAIL %s_contig got=%0d want=%0d", nm, rx_t[NB-1] - rx_t[0], (NB - 1) * 10 * DIV); end
      checks++;
      if (fd_t.size() != 1) begin failures++; $display("FAIL %s_fd_count got=%0d want=1", nm, fd_t.size()); end
      else begin
        // Start-bit cycle counted as the first; frame_done lands in cycle FRAME_CYC.
        checks++; if (fd_t[0] - rx_t[0] + 1 != FRAME_CYC) begin failures++; $display("FAIL %s_fd_time got=%0d want=%0d", nm, fd_t[0] - rx_t[0] + 1, FRAME_CYC); end
      end
    end
    checks++; if (width_err != 0 || frame_err != 0) begin failures++; $display("FAIL %s_bit_timing got=%0d/%0d want=0/0", nm, width_err, frame_err); end
    wait_idle(GAP + 50, ok);
    checks++; if (!ok) begin failures++; $display("FAIL %s_idle got=busy want=idle", nm); end
  endtask

  task automatic test_play_track();
    logic [7:0] lit [10];
`ifdef DFP_CHECKSUM_EN
    lit = '{8'h7E, 8'hFF, 8'h06, 8'h03, 8'h00, 8'h00, 8'h01, 8'hFE, 8'hF7, 8'hEF};
`else
    lit = '{8'h7E, 8'hFF, 8'h06, 8'h03, 8'h00, 8'h00, 8'h01, 8'hEF, 8'h00, 8'h00};
`endif
    test_single("play", 8'h03, 16'h0001, 1'b0, lit);
  endtask

  task automatic test_set_volume();
    logic [7:0] lit [10];
`ifdef DFP_CHECKSUM_EN
    lit = '{8'h7E, 8'hFF, 8'h06, 8'h06, 8'h01, 8'h00, 8'h1E, 8'hFE, 8'hD6, 8'hEF};
`else
    lit = '{8'h7E, 8'hFF, 8'h06, 8'h06, 8'h01, 8'h00, 8'h1E, 8'hEF, 8'h00, 8'h00};
`endif
    test_single("volume", 8'h06, 16'h001E, 1'b1, lit);
  endtask

  // Fill the FIFO while a frame is on the wire; refused commands must never appear.
  task automatic test_back_to_back();
    bit ok, acc; int unsigned at; int lvl, nacc, b; logic [7:0] got, e, c; logic [15:0] p; logic f;
    clear_sb();
    exp_frame(8'h03, 16'h0005, 1'b0);
    offer(8'h03, 16'h0005, 1'b0, acc, at);
    b = 20;
    while (!(busy === 1'b1 && fifo_level === '0) && b > 0) begin @(negedge clk); b--; end
    checks++; if (b == 0) begin failures++; $display("FAIL b2b_first_pop got=level%0d want=level0", fifo_level); end
    lvl = 0; nacc = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      c = 8'h40 + 8'(i); p = 16'h0100 + 16'(i); f = i[0];
      offer(c, p, f, acc, at);
      checks++; if (acc !== (lvl != DEPTH)) begin failures++; $display("FAIL b2b_ready%0d got=%b want=%b", i, acc, lvl != DEPTH); end
      if (acc) begin exp_frame(c, p, f); lvl++; nacc++; end
      checks++; if (fifo_level !== LW'(lvl)) begin failures++; $display("FAIL b2b_level%0d got=%0d want=%0d", i, fifo_level, lvl); end
      checks++; if (cmd_ready !== (lvl != DEPTH)) begin failures++; $display("FAIL b2b_ready_after%0d got=%b want=%b", i, cmd_ready, lvl != DEPTH); end
    end
    checks++; if (nacc != DEPTH) begin failures++; $display("FAIL b2b_accepted got=%0d want=%0d", nacc, DEPTH); end
    wait_rx((DEPTH + 1) * NB, (DEPTH + 1) * (FRAME_CYC + GAP + 10) + 200, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL b2b_timeout got=%0d bytes want=%0d", rx_q.size(), (DEPTH + 1) * NB);
    end else begin
      for (int i = 0; i < (DEPTH + 1) * NB; i++) begin
        got = rx_q.pop_front(); e = exp_q.pop_front();
        checks++; if (got !== e) begin failures++; $display("FAIL b2b_byte%0d got=%h want=%h", i, got, e); end
      end
      checks++;
      if (fd_t.size() != DEPTH + 1) begin failures++; $display("FAIL b2b_fd_count got=%0d want=%0d", fd_t.size(), DEPTH + 1); end
      else begin
        for (int fr = 1; fr <= DEPTH; fr++) begin
          checks++; if (rx_t[fr*NB] - fd_t[fr-1] < GAP + 2) begin failures++; $display("FAIL b2b_gap%0d got=%0d want>=%0d", fr, rx_t[fr*NB] - fd_t[fr-1], GAP + 2); end
          checks++; if (fd_t[fr] - rx_t[fr*NB] + 1 != FRAME_CYC) begin failures++; $display("FAIL b2b_len%0d got=%0d want=%0d", fr, fd_t[fr] - rx_t[fr*NB] + 1, FRAME_CYC); end
        end
      end
    end
    repeat (2 * FRAME_CYC) @(negedge clk);
    checks++; if (rx_q.size() != 0) begin failures++; $display("FAIL b2b_extra got=%0d bytes want=0", rx_q.size()); end
    checks++; if (width_err != 0 || frame_err != 0) begin failures++; $display("FAIL b2b_bit_timing got=%0d/%0d want=0/0", width_err, frame_err); end
  endtask

  // Reset in the middle of byte 4 abandons the frame and flushes the queue.
  task automatic test_reset_midframe();
    bit ok, acc; int unsigned at; logic [7:0] got, e;
    clear_sb();
    exp_frame(8'h06, 16'h0A0B, 1'b1);
    offer(8'h06, 16'h0A0B, 1'b1, acc, at);
    offer(8'h03, 16'h0007, 1'b0, acc, at);
    offer(8'h03, 16'h0008, 1'b0, acc, at);
    wait_rx(3, 5 * 10 * DIV, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL rst_prefix_timeout got=%0d bytes want=3", rx_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        got = rx_q.pop_front(); e = exp_q.pop_front();
        checks++; if (got !== e) begin failures++; $display("FAIL rst_prefix%0d got=%h want=%h", i, got, e); end
      end
    end
    repeat (5 * DIV) @(negedge clk);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    checks++; if (tx !== 1'b1) begin failures++; $display("FAIL rst_tx got=%b want=1", tx); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b want=0", busy); end
    checks++; if (fifo_level !== '0) begin failures++; $display("FAIL rst_level got=%0d want=0", fifo_level); end
    @(posedge clk); #2;
    reset_n = 1'b1;
    clear_sb();
    repeat (3 * FRAME_CYC) @(negedge clk);
    checks++; if (rx_q.size() != 0) begin failures++; $display("FAIL rst_silent got=%0d bytes want=0", rx_q.size()); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy_after got=%b want=0", busy); end
    exp_frame(8'h03, 16'h0002, 1'b0);
    offer(8'h03, 16'h0002, 1'b0, acc, at);
    wait_rx(NB, FRAME_CYC + 200, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL rst_recover_timeout got=%0d bytes want=%0d", rx_q.size(), NB);
    end else begin
      for (int i = 0; i < NB; i++) begin
        got = rx_q.pop_front(); e = exp_q.pop_front();
        checks++; if (got !== e) begin failures++; $display("FAIL rst_recover%0d got=%h want=%h", i, got, e); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_play_track();
    test_set_volume();
    test_back_to_back();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

endmodule
